load_store_unit: RTL and testbench

Memory-access stage of the RV32I core. Takes LOAD/STORE operations from execute (effective address already computed), runs one data-memory transaction over a req/gnt/rvalid bus, and returns sign- or zero-extended load data, or a store completion, to writeback. Misaligned accesses and unsupported funct3 encodings are trapped locally and never reach the bus. One operation is in flight at a time.

---
 rtl/load_store_unit.sv | 106 ++++++++++
 tb/tb_load_store_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory stage running one req/gnt/rvalid data transaction per load/store, with local misaligned/illegal traps
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic [1:0]        wb_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, nxt;
  logic [2:0] f3;
  logic [ADDR_W-1:0] addr;
  logic [31:0] wdata;
  logic [4:0] rd;
  logic st, ill, mis, is_req;
  logic [3:0] be;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] ld;
  logic wb_valid_n;
  logic [4:0] wb_rd_n;
  logic [31:0] wb_data_n;
  logic [1:0] wb_err_n;
  assign ill = ex_is_store ? ex_funct3 >= 3'd3 : (ex_funct3 == 3'd3 || ex_funct3[2:1] == 2'b11);
  assign mis = (ex_funct3[1:0] == 2'd1 && ex_addr[0]) || (ex_funct3[1:0] == 2'd2 && ex_addr[1:0] != 2'd0);
  assign ex_ready = state == IDLE;
  assign is_req = state == REQ;
  assign be = f3[1:0] == 2'd0 ? 4'b0001 << addr[1:0] : f3[1:0] == 2'd1 ? 4'b0011 << addr[1:0] : 4'b1111;
  assign mem_req = is_req;
  assign mem_we = is_req & st;
  assign mem_addr = is_req ? {addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be = is_req ? be : '0;
  assign mem_wdata = !is_req ? '0 : f3[1:0] == 2'd0 ? {4{wdata[7:0]}} : f3[1:0] == 2'd1 ? {2{wdata[15:0]}} : wdata;
  assign b = mem_rdata[{addr[1:0], 3'b000} +: 8];
  assign h = mem_rdata[{addr[1], 4'b0000} +: 16];
  assign ld = f3[1:0] == 2'd0 ? {{24{~f3[2] & b[7]}}, b} : f3[1:0] == 2'd1 ? {{16{~f3[2] & h[15]}}, h} : mem_rdata;
  always_comb begin
    nxt = state;
    wb_valid_n = 1'b0;
    wb_rd_n = '0;
    wb_data_n = '0;
    wb_err_n = 2'b00;
    case (state)
      IDLE: if (ex_valid) begin
        nxt = (ill || mis) ? RESP : REQ;
        wb_valid_n = ill || mis;
        wb_err_n = ill ? 2'b10 : mis ? 2'b01 : 2'b00;
      end
      REQ: nxt = mem_gnt ? WAIT : REQ;
      WAIT: if (mem_rvalid) begin
        nxt = RESP;
        wb_valid_n = 1'b1;
        wb_err_n = mem_err ? 2'b11 : 2'b00;
        wb_rd_n = (st || mem_err) ? 5'd0 : rd;
        wb_data_n = (st || mem_err) ? 32'd0 : ld;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      f3 <= '0;
      addr <= '0;
      wdata <= '0;
      rd <= '0;
      st <= 1'b0;
      wb_valid <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      wb_err <= '0;
    end else begin
      state <= nxt;
      wb_valid <= wb_valid_n;
      wb_rd <= wb_rd_n;
      wb_data <= wb_data_n;
      wb_err <= wb_err_n;
      if (state == IDLE && ex_valid) begin
        f3 <= ex_funct3;
        addr <= ex_addr;
        wdata <= ex_wdata;
        rd <= ex_rd;
        st <= ex_is_store;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven scoreboard bench for load_store_unit
module tb_load_store_unit;
  logic clk = 0, rst_n = 0;
  logic ex_valid = 0, ex_ready, ex_is_store = 0;
  logic [2:0] ex_funct3 = 0;
  logic [31:0] ex_addr = 0, ex_wdata = 0;
  logic [4:0] ex_rd = 0;
  logic mem_req, mem_we, mem_gnt = 0, mem_rvalid = 0, mem_err = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0] mem_be;
  logic wb_valid;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  logic [1:0] wb_err;
  int cyc = 0, nchk = 0, nerr = 0;

  typedef struct {
    logic st; logic [2:0] f3; logic [31:0] addr, wdata; logic [4:0] rd;
    logic [31:0] rdata; logic berr; int gdly;
    logic bus; logic [3:0] be; logic [31:0] mwd, data; logic [1:0] err; logic [4:0] erd; int lat;
  } vec_t;

  vec_t tbl[14];
  vec_t q[$];

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] rd, input logic [31:0] rdata, input logic berr, input int gdly,
                              input logic bus, input logic [3:0] be, input logic [31:0] mwd, input logic [31:0] data,
                              input logic [1:0] err, input logic [4:0] erd, input int lat);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd; v.rdata = rdata; v.berr = berr;
    v.gdly = gdly; v.bus = bus; v.be = be; v.mwd = mwd; v.data = data; v.err = err; v.erd = erd; v.lat = lat;
    return v;
  endfunction

  task automatic run(input vec_t v);
    int t0, nreq;
    logic gp, saw, got;
    vec_t e;
    @(negedge clk);
    chk("ready_idle", ex_ready, 1);
    ex_valid = 1; ex_is_store = v.st; ex_funct3 = v.f3; ex_addr = v.addr; ex_wdata = v.wdata; ex_rd = v.rd;
    t0 = cyc;
    q.push_back(v);
    @(negedge clk);
    ex_valid = 0;
    nreq = 0; gp = 0; saw = 0; got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      mem_gnt = 0; mem_rvalid = 0;
      if (k == 0) chk("ready_busy", ex_ready, 0);
      if (mem_req) begin
        saw = 1;
        chk("mem_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
        chk("mem_be", {28'd0, mem_be}, {28'd0, v.be});
        chk("mem_we", {31'd0, mem_we}, {31'd0, v.st});
        if (v.st) chk("mem_wdata", mem_wdata, v.mwd);
        if (nreq == v.gdly) mem_gnt = 1;
        nreq++;
      end
      if (wb_valid) begin
        got = 1;
        chk("q_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("latency", cyc - t0, e.lat);
          chk("wb_data", wb_data, e.data);
          chk("wb_err", {30'd0, wb_err}, {30'd0, e.err});
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.erd});
        end
      end else begin
        if (gp) begin
          mem_rvalid = 1; mem_rdata = v.rdata; mem_err = v.berr;
        end
        gp = mem_gnt;
        @(negedge clk);
      end
    end
    mem_gnt = 0; mem_rvalid = 0;
    chk("wb_seen", {31'd0, got}, 1);
    chk("bus_used", {31'd0, saw}, {31'd0, v.bus});
    @(negedge clk);
    chk("wb_pulse_once", {31'd0, wb_valid}, 0);
  endtask

  initial begin
    tbl[0]  = mk(0, 3'b000, 32'h1003, 0, 5, 32'h80FF_1234, 0, 0, 1, 4'b1000, 0, 32'hFFFF_FF80, 2'b00, 5, 3);
    tbl[1]  = mk(0, 3'b100, 32'h1003, 0, 6, 32'h80FF_1234, 0, 0, 1, 4'b1000, 0, 32'h0000_0080, 2'b00, 6, 3);
    tbl[2]  = mk(0, 3'b001, 32'h2002, 0, 7, 32'h8001_0000, 0, 0, 1, 4'b1100, 0, 32'hFFFF_8001, 2'b00, 7, 3);
    tbl[3]  = mk(0, 3'b010, 32'h2001, 0, 8, 0, 0, 0, 0, 4'b0000, 0, 0, 2'b01, 0, 1);
    tbl[4]  = mk(1, 3'b000, 32'h3001, 32'h0000_00AB, 9, 0, 0, 0, 1, 4'b0010, 32'hABAB_ABAB, 0, 2'b00, 0, 3);
    tbl[5]  = mk(1, 3'b001, 32'h3002, 32'h1234_5678, 10, 0, 0, 0, 1, 4'b1100, 32'h5678_5678, 0, 2'b00, 0, 3);
    tbl[6]  = mk(0, 3'b010, 32'h4000, 0, 11, 32'hDEAD_BEEF, 0, 3, 1, 4'b1111, 0, 32'hDEAD_BEEF, 2'b00, 11, 6);
    tbl[7]  = mk(0, 3'b110, 32'h5000, 0, 12, 0, 0, 0, 0, 4'b0000, 0, 0, 2'b10, 0, 1);
    tbl[8]  = mk(0, 3'b010, 32'h6000, 0, 13, 32'h1234_5678, 1, 0, 1, 4'b1111, 0, 0, 2'b11, 0, 3);
    tbl[9]  = mk(0, 3'b101, 32'h7002, 0, 14, 32'h8001_0000, 0, 0, 1, 4'b1100, 0, 32'h0000_8001, 2'b00, 14, 3);
    tbl[10] = mk(1, 3'b011, 32'h0001, 0, 15, 0, 0, 0, 0, 4'b0000, 0, 0, 2'b10, 0, 1);
    tbl[11] = mk(1, 3'b010, 32'h8000, 32'hCAFE_F00D, 16, 0, 0, 0, 1, 4'b1111, 32'hCAFE_F00D, 0, 2'b00, 0, 3);
    tbl[12] = mk(0, 3'b000, 32'h9000, 0, 17, 32'h0000_007F, 0, 1, 1, 4'b0001, 0, 32'h0000_007F, 2'b00, 17, 4);
    tbl[13] = mk(0, 3'b001, 32'h9001, 0, 18, 0, 0, 0, 0, 4'b0000, 0, 0, 2'b01, 0, 1);

    repeat (2) @(negedge clk);
    chk("rst_ex_ready", {31'd0, ex_ready}, 1);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_mem_be", {28'd0, mem_be}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_err", {30'd0, wb_err}, 0);
    rst_n = 1;

    for (int i = 0; i < 14; i++) run(tbl[i]);

    @(negedge clk);
    ex_valid = 1; ex_is_store = 0; ex_funct3 = 3'b010; ex_addr = 32'h4000; ex_rd = 3;
    @(negedge clk);
    ex_valid = 0;
    chk("rs_req", {31'd0, mem_req}, 1);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    chk("rs_wait_noreq", {31'd0, mem_req}, 0);
    rst_n = 0;
    #1;
    chk("rs_async_ready", {31'd0, ex_ready}, 1);
    chk("rs_async_wb", {31'd0, wb_valid}, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 32'h5555_AAAA; mem_err = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_rvalid = 0;
      chk("rs_no_wb", {31'd0, wb_valid}, 0);
      chk("rs_ready", {31'd0, ex_ready}, 1);
    end
    run(tbl[2]);
    chk("q_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
